uart_mem_loader: RTL and testbench

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

---
 rtl/uart_mem_loader_if.sv | 13 +
 rtl/uart_mem_loader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_if.sv
// Memory-port bundle between the UART loader (master) and the target memory (slave).
// mem_rdata is expected one clk after mem_addr is presented.
interface uart_mem_loader_if #(
    parameter int XADR = 18
);
    logic [3:0]      mem_wen;
    logic [XADR-1:0] mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;

    modport master (output mem_wen, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_wen, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/uart_mem_loader.sv
// UART (8N1) host loader: 'W' addr[4] data[4] writes a word (ACK 0x06), 'R' addr[4] reads one back.
// Optional macro UART_LOADER_TIMEOUT_EN aborts a half-received command after TMO_BITS idle bit periods.
module uart_mem_loader #(
    parameter int XADR     = 18,
    parameter int DIV      = 868,
    parameter int TMO_BITS = 64
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rxd,
    output logic              uart_txd,
    output logic              busy,
    uart_mem_loader_if.master mem
);
    if (DIV < 4 || TMO_BITS < 1) begin : g_param_check
        $error("uart_mem_loader: DIV must be >= 4 and TMO_BITS >= 1");
    end

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MEMW, S_MEMR, S_MEMR_WAIT, S_RESP} cmd_state_t;

    rx_state_t       r_rx_st;
    logic [2:0]      r_rxd_sync;
    logic [CW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            r_rx_vld;
    logic            r_rx_ferr;

    cmd_state_t      r_st;
    logic            r_is_wr;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_word;
    logic [2:0]      r_resp_left;
    logic            r_busy;
    logic            r_txd;
    logic [8:0]      r_tx_shift;
    logic [3:0]      r_tx_bits;
    logic [CW-1:0]   r_tx_cnt;
    logic            r_tx_act;
    logic [3:0]      r_mem_wen;
    logic [XADR-1:0] r_mem_addr;
    logic [31:0]     r_mem_wdata;

    logic [31:0] w_addr_next;
    logic [31:0] w_word_next;
    logic        w_rxd;
    logic        w_tx_done;
    logic        w_unused;

    assign w_rxd       = r_rxd_sync[1];
    assign w_addr_next = {r_rx_shift, r_addr[31:8]};
    assign w_word_next = {r_rx_shift, r_word[31:8]};
    assign w_tx_done   = r_tx_act && (r_tx_cnt == BIT_END) && (r_tx_bits == 4'd0);
    assign w_unused    = ^{w_addr_next[1:0], w_addr_next[31:XADR+2], r_addr[1:0], r_word[7:0]};

    assign uart_txd      = r_txd;
    assign busy          = r_busy;
    assign mem.mem_wen   = r_mem_wen;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

    // Sync flops reset low: a falling edge needs a high synchronized sample first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_st    <= RX_IDLE;
            r_rxd_sync <= 3'b000;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_vld   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rxd_sync <= {r_rxd_sync[1:0], uart_rxd};
            r_rx_vld   <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rxd_sync[2] && !w_rxd) r_rx_st <= RX_START;
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_END) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= 3'd0;
                        r_rx_st  <= w_rxd ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == BIT_END) begin
                        r_rx_cnt  <= '0;
                        r_rx_st   <= RX_IDLE;
                        r_rx_vld  <= w_rxd;
                        r_rx_ferr <= !w_rxd;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic tx_start(input logic [7:0] b);
        r_txd      <= 1'b0;
        r_tx_shift <= {1'b1, b};
        r_tx_bits  <= 4'd9;
        r_tx_cnt   <= '0;
        r_tx_act   <= 1'b1;
    endtask

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int TMO_CLKS = TMO_BITS * DIV;
    localparam int TW       = $clog2(TMO_CLKS);
    localparam logic [TW-1:0] TMO_END = TW'(TMO_CLKS - 1);
    logic [TW-1:0] r_tmo_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st        <= S_IDLE;
            r_is_wr     <= 1'b0;
            r_byte_cnt  <= 2'd0;
            r_addr      <= 32'h0;
            r_word      <= 32'h0;
            r_resp_left <= 3'd0;
            r_busy      <= 1'b0;
            r_txd       <= 1'b1;
            r_tx_shift  <= 9'h1FF;
            r_tx_bits   <= 4'd0;
            r_tx_cnt    <= '0;
            r_tx_act    <= 1'b0;
            r_mem_wen   <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
`ifdef UART_LOADER_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            // Transmitter shifts here; the command states below may reload it.
            if (r_tx_act) begin
                if (r_tx_cnt == BIT_END) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bits == 4'd0) begin
                        r_tx_act <= 1'b0;
                    end else begin
                        r_txd      <= r_tx_shift[0];
                        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                        r_tx_bits  <= r_tx_bits - 1'b1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end

            case (r_st)
                S_IDLE: begin
                    if (r_rx_vld) begin
                        if (r_rx_shift == 8'h57 || r_rx_shift == 8'h52) begin
                            r_is_wr    <= (r_rx_shift == 8'h57);
                            r_byte_cnt <= 2'd0;
                            r_busy     <= 1'b1;
                            r_st       <= S_ADDR;
                        end else begin
                            tx_start(8'h15);
                            r_resp_left <= 3'd1;
                            r_st        <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (r_rx_ferr) begin
                        r_busy <= 1'b0;
                        r_st   <= S_IDLE;
                    end else if (r_rx_vld) begin
                        r_addr     <= w_addr_next;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_is_wr) begin
                                r_st <= S_DATA;
                            end else begin
                                r_mem_addr <= w_addr_next[XADR+1:2];
                                r_st       <= S_MEMR;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (r_rx_ferr) begin
                        r_busy <= 1'b0;
                        r_st   <= S_IDLE;
                    end else if (r_rx_vld) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_wen   <= 4'hF;
                            r_mem_wdata <= w_word_next;
                            r_mem_addr  <= r_addr[XADR+1:2];
                            r_st        <= S_MEMW;
                        end
                    end
                end
                S_MEMW: begin
                    r_mem_wen <= 4'h0;
                    tx_start(8'h06);
                    r_resp_left <= 3'd1;
                    r_st        <= S_RESP;
                end
                S_MEMR: r_st <= S_MEMR_WAIT;
                S_MEMR_WAIT: begin
                    r_word <= mem.mem_rdata;
                    tx_start(mem.mem_rdata[7:0]);
                    r_resp_left <= 3'd4;
                    r_st        <= S_RESP;
                end
                default: begin
                    if (w_tx_done) begin
                        if (r_resp_left == 3'd1) begin
                            r_busy <= 1'b0;
                            r_st   <= S_IDLE;
                        end else begin
                            r_word      <= {8'h00, r_word[31:8]};
                            r_resp_left <= r_resp_left - 1'b1;
                            tx_start(r_word[15:8]);
                        end
                    end
                end
            endcase

`ifdef UART_LOADER_TIMEOUT_EN
            // Only a quiet line counts toward the timeout; any frame in flight restarts it.
            if ((r_st == S_ADDR || r_st == S_DATA) && r_rx_st == RX_IDLE && !r_rx_vld) begin
                if (r_tmo_cnt == TMO_END) begin
                    r_tmo_cnt <= '0;
                    r_busy    <= 1'b0;
                    r_st      <= S_IDLE;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end else begin
                r_tmo_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: directed scenarios plus random W/R/NAK traffic,
// expected tx bytes and memory writes queued by a word-array reference model.
module tb_uart_mem_loader;
    localparam int XADR     = 8;
    localparam int DIV      = 4;
    localparam int TMO_BITS = 8;
    localparam int WORDS    = 1 << XADR;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic uart_rxd = 1'b1;
    logic uart_txd;
    logic busy;
    logic mem_init = 1'b1;

    int nchk = 0;
    int nerr = 0;

    logic [7:0]          exp_tx[$];
    logic [XADR+31:0]    exp_wr[$];
    logic [31:0]         ref_mem [WORDS];
    logic [31:0]         sim_mem [WORDS];

    uart_mem_loader_if #(.XADR(XADR)) mif ();

    uart_mem_loader #(.XADR(XADR), .DIV(DIV), .TMO_BITS(TMO_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd),
        .uart_txd(uart_txd), .busy(busy), .mem(mif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    // Target memory: synchronous read, one clk latency.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) sim_mem[i] <= init_word(i);
        end else if (mif.mem_wen == 4'hF) begin
            sim_mem[mif.mem_addr] <= mif.mem_wdata;
        end
        mif.mem_rdata <= sim_mem[mif.mem_addr];
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // TX monitor: independent UART receiver popping the expected-byte queue.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && uart_txd === 1'b0) begin
                repeat (DIV/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (DIV) @(negedge clk);
                chk("tx_stop", {63'd0, uart_txd}, 64'd1);
                if (exp_tx.size() == 0) chk("tx_unexpected", {56'd0, b}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("tx_byte", {56'd0, b}, {56'd0, exp_tx.pop_front()});
            end
        end
    end

    // Write monitor: every enabled cycle must match the next expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (mif.mem_wen !== 4'h0) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", {60'd0, mif.mem_wen}, 64'd0);
                end else begin
                    logic [XADR+31:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_wen", {60'd0, mif.mem_wen}, 64'hF);
                    chk("wr_addr", {{(64-XADR){1'b0}}, mif.mem_addr}, {{(64-XADR){1'b0}}, e[XADR+31:32]});
                    chk("wr_data", {32'd0, mif.mem_wdata}, {32'd0, e[31:0]});
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (DIV) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2*DIV) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        logic [XADR-1:0] wa;
        wa = addr[XADR+1:2];
        exp_wr.push_back({wa, data});
        ref_mem[wa] = data;
        exp_tx.push_back(8'h06);
        send_byte(8'h57, 1'b1);
        chk("busy_after_W", {63'd0, busy}, 64'd1);
        send_word(addr);
        send_word(data);
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic [31:0] v;
        v = ref_mem[addr[XADR+1:2]];
        for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
        send_byte(8'h52, 1'b1);
        chk("busy_after_R", {63'd0, busy}, 64'd1);
        send_word(addr);
    endtask

    task automatic do_bad(input logic [7:0] b);
        exp_tx.push_back(8'h15);
        send_byte(b, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_pending"}, 64'(exp_tx.size() + exp_wr.size()), 64'd0);
        repeat (DIV + 2) @(negedge clk);
        chk({name, "_busy_low"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] a, d;
        int          kind;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        chk("rst_txd",   {63'd0, uart_txd}, 64'd1);
        chk("rst_wen",   {60'd0, mif.mem_wen}, 64'd0);
        chk("rst_addr",  {{(64-XADR){1'b0}}, mif.mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mif.mem_wdata}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        wait_done("write_deadbeef");

        do_write(32'h0000_0010, 32'h1234_5678);
        wait_done("preload");
        do_read(32'h0000_0013);
        wait_done("read_word4");
        chk("read_mem_addr", {{(64-XADR){1'b0}}, mif.mem_addr}, 64'd4);

        do_bad(8'h41);
        wait_done("nak_41");

        send_byte(8'h57, 1'b1);
        chk("ferr_busy_before", {63'd0, busy}, 64'd1);
        send_byte(8'hA5, 1'b0);
        chk("ferr_busy_after", {63'd0, busy}, 64'd0);
        repeat (20*DIV) @(negedge clk);
        do_write(32'h0000_0020, 32'h0BAD_F00D);
        wait_done("after_ferr");

        for (int n = 0; n < 20; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            d = $urandom;
            if (kind == 0) begin
                do_write(a, d);
            end else if (kind == 1) begin
                do_read(a);
            end else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h57 || b == 8'h52) b = b ^ 8'h01;
                do_bad(b);
            end
            wait_done("random");
        end

        send_byte(8'h57, 1'b1);
        send_word(32'h0000_0044);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        @(negedge clk) uart_rxd = 1'b0;
        repeat (3*DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_txd",   {63'd0, uart_txd}, 64'd1);
        chk("abort_wen",   {60'd0, mif.mem_wen}, 64'd0);
        chk("abort_addr",  {{(64-XADR){1'b0}}, mif.mem_addr}, 64'd0);
        chk("abort_wdata", {32'd0, mif.mem_wdata}, 64'd0);
        chk("abort_busy",  {63'd0, busy}, 64'd0);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_idle_busy", {63'd0, busy}, 64'd0);

        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (40) @(negedge clk);
`ifdef UART_LOADER_TIMEOUT_EN
        chk("timeout_busy", {63'd0, busy}, 64'd0);
        repeat (20*DIV) @(negedge clk);
`else
        chk("no_timeout_busy", {63'd0, busy}, 64'd1);
        d = ref_mem[4];
        for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_done("no_timeout_read");
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
